// File: rtl/xbar_pipe_pkg.sv
// Shared constants for the pipelined crossbar: arbitration modes, default sizes
// and the width of a port index.
package xbar_pipe_pkg;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    localparam int DEF_NUM_PORT   = 4;
    localparam int DEF_DATA_WIDTH = 64;

    // A port index always needs at least one bit, even for a 2-port crossbar.
    function automatic int ptrWidth(input int numPort);
        return (numPort <= 2) ? 1 : $clog2(numPort);
    endfunction

endpackage

// File: rtl/xbar_rr_arb.sv
// Single-output arbiter: picks one requester per cycle, either lowest index first
// or round-robin starting from the slot after the previous winner.
module xbar_rr_arb
    import xbar_pipe_pkg::*;
#(
    parameter int NUM_PORT = DEF_NUM_PORT,
    parameter int ARB_MODE = ARB_RR,
    localparam int PTR_W   = ptrWidth(NUM_PORT)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_PORT-1:0] req_i,
    output logic [NUM_PORT-1:0] gnt_o
);

    logic [PTR_W-1:0]    ptr_q;
    logic [PTR_W-1:0]    ptr_d;
    logic [NUM_PORT-1:0] gnt;
    logic                found;

    // Two passes: requesters at or above the pointer first, then the wrapped ones.
    // With the pointer pinned at 0 this degenerates to lowest-index-wins.
    always_comb begin
        gnt   = '0;
        ptr_d = ptr_q;
        found = 1'b0;
        for (int i = 0; i < NUM_PORT; i++) begin
            if (!found && req_i[i] && (i >= int'(ptr_q))) begin
                found  = 1'b1;
                gnt[i] = 1'b1;
                ptr_d  = (i == NUM_PORT - 1) ? '0 : PTR_W'(i + 1);
            end
        end
        for (int i = 0; i < NUM_PORT; i++) begin
            if (!found && req_i[i]) begin
                found  = 1'b1;
                gnt[i] = 1'b1;
                ptr_d  = (i == NUM_PORT - 1) ? '0 : PTR_W'(i + 1);
            end
        end
        if (ARB_MODE == ARB_FIXED) begin
            ptr_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign gnt_o = gnt;

endmodule

// File: rtl/xbar_pipe.sv
// N x N switch-traversal crossbar with per-output arbitration, multicast requests,
// per-output stall and a registered output stage.
module xbar_pipe
    import xbar_pipe_pkg::*;
#(
    parameter int NUM_PORT   = DEF_NUM_PORT,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ARB_MODE   = ARB_RR,
    localparam int PTR_W     = ptrWidth(NUM_PORT)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_PORT*DATA_WIDTH-1:0] in_data,
    input  logic [NUM_PORT-1:0]            in_valid,
    input  logic [NUM_PORT*NUM_PORT-1:0]   in_req,
    input  logic [NUM_PORT-1:0]            out_stall,
    output logic [NUM_PORT*NUM_PORT-1:0]   gnt,
    output logic [NUM_PORT*DATA_WIDTH-1:0] out_data,
    output logic [NUM_PORT-1:0]            out_valid,
    output logic [NUM_PORT*PTR_W-1:0]      out_src
);

    logic [NUM_PORT-1:0][NUM_PORT-1:0]   effCol;
    logic [NUM_PORT-1:0][NUM_PORT-1:0]   gntCol;
    logic [NUM_PORT-1:0][PTR_W-1:0]      winIdx;
    logic [NUM_PORT-1:0][DATA_WIDTH-1:0] winData;

    logic [NUM_PORT-1:0][DATA_WIDTH-1:0] outData_q;
    logic [NUM_PORT-1:0][DATA_WIDTH-1:0] outData_d;
    logic [NUM_PORT-1:0]                 outValid_q;
    logic [NUM_PORT-1:0]                 outValid_d;
    logic [NUM_PORT-1:0][PTR_W-1:0]      outSrc_q;
    logic [NUM_PORT-1:0][PTR_W-1:0]      outSrc_d;

    // Requests are regrouped per output column; a stalled output sees no requests,
    // so its arbiter neither grants nor advances its pointer.
    always_comb begin
        effCol = '0;
        for (int j = 0; j < NUM_PORT; j++) begin
            for (int i = 0; i < NUM_PORT; i++) begin
                effCol[j][i] = in_valid[i] & in_req[i*NUM_PORT + j] & ~out_stall[j];
            end
        end
    end

    for (genvar j = 0; j < NUM_PORT; j++) begin : g_arb
        xbar_rr_arb #(
            .NUM_PORT (NUM_PORT),
            .ARB_MODE (ARB_MODE)
        ) u_arb (
            .clk   (clk),
            .reset (reset),
            .req_i (effCol[j]),
            .gnt_o (gntCol[j])
        );
    end

    always_comb begin
        gnt = '0;
        for (int j = 0; j < NUM_PORT; j++) begin
            for (int i = 0; i < NUM_PORT; i++) begin
                gnt[i*NUM_PORT + j] = gntCol[j][i];
            end
        end
    end

    // Grants are one-hot, so OR-reduction yields the winner's index and flit,
    // and both come out as zero when the output has no grant.
    always_comb begin
        winIdx  = '0;
        winData = '0;
        for (int j = 0; j < NUM_PORT; j++) begin
            for (int i = 0; i < NUM_PORT; i++) begin
                if (gntCol[j][i]) begin
                    winIdx[j]  = winIdx[j] | PTR_W'(i);
                    winData[j] = winData[j] | in_data[i*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    always_comb begin
        outData_d  = outData_q;
        outValid_d = outValid_q;
        outSrc_d   = outSrc_q;
        for (int j = 0; j < NUM_PORT; j++) begin
            if (!out_stall[j]) begin
                outValid_d[j] = |gntCol[j];
                outData_d[j]  = winData[j];
                outSrc_d[j]   = winIdx[j];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            outData_q  <= '0;
            outValid_q <= '0;
            outSrc_q   <= '0;
        end else begin
            outData_q  <= outData_d;
            outValid_q <= outValid_d;
            outSrc_q   <= outSrc_d;
        end
    end

    assign out_data  = outData_q;
    assign out_valid = outValid_q;
    assign out_src   = outSrc_q;

endmodule

// File: tb/tb_xbar_pipe.sv
// Bench for xbar_pipe: a fixed-priority and a round-robin instance share stimulus
// and are checked against a behavioural model through a scoreboard queue.
module tb_xbar_pipe;

    localparam int N  = 4;
    localparam int W  = 64;
    localparam int PW = 2;

    typedef struct packed {
        logic [N-1:0]    valid;
        logic [N*W-1:0]  data;
        logic [N*PW-1:0] src;
    } expOut_t;

    typedef struct packed {
        expOut_t fix;
        expOut_t rr;
    } expPair_t;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [N*W-1:0] inData = '0;
    logic [N-1:0]   inValid = '0;
    logic [N*N-1:0] inReq = '0;
    logic [N-1:0]   outStall = '0;

    logic [N*N-1:0]  gntFix, gntRr;
    logic [N*W-1:0]  outDataFix, outDataRr;
    logic [N-1:0]    outValidFix, outValidRr;
    logic [N*PW-1:0] outSrcFix, outSrcRr;

    int testsRun = 0;
    int testsFailed = 0;

    expPair_t       sbq[$];
    int             mPtr [N];
    expOut_t        mFix, mRr;
    logic [N*N-1:0] expGntFix, expGntRr;

    always #5 clk = ~clk;

    xbar_pipe #(.NUM_PORT(N), .DATA_WIDTH(W), .ARB_MODE(0)) dutFix (
        .clk(clk), .reset(reset), .in_data(inData), .in_valid(inValid),
        .in_req(inReq), .out_stall(outStall), .gnt(gntFix),
        .out_data(outDataFix), .out_valid(outValidFix), .out_src(outSrcFix)
    );

    xbar_pipe #(.NUM_PORT(N), .DATA_WIDTH(W), .ARB_MODE(1)) dutRr (
        .clk(clk), .reset(reset), .in_data(inData), .in_valid(inValid),
        .in_req(inReq), .out_stall(outStall), .gnt(gntRr),
        .out_data(outDataRr), .out_valid(outValidRr), .out_src(outSrcRr)
    );

    function automatic int winner(input int j, input int start);
        for (int k = 0; k < N; k++) begin
            int i;
            i = (start + k) % N;
            if (inValid[i] && inReq[i*N + j] && !outStall[j]) return i;
        end
        return -1;
    endfunction

    task automatic clearModel();
        for (int j = 0; j < N; j++) mPtr[j] = 0;
        mFix = '0;
        mRr  = '0;
    endtask

    // Computes this cycle's expected grants and queues the outputs due after the edge.
    task automatic stepModel();
        expPair_t nxt;
        int       wf, wr;
        nxt.fix   = mFix;
        nxt.rr    = mRr;
        expGntFix = '0;
        expGntRr  = '0;
        for (int j = 0; j < N; j++) begin
            wf = winner(j, 0);
            wr = winner(j, mPtr[j]);
            if (!outStall[j]) begin
                nxt.fix.valid[j] = 1'b0;
                nxt.fix.data[j*W +: W] = '0;
                nxt.fix.src[j*PW +: PW] = '0;
                nxt.rr.valid[j] = 1'b0;
                nxt.rr.data[j*W +: W] = '0;
                nxt.rr.src[j*PW +: PW] = '0;
            end
            if (wf >= 0) begin
                expGntFix[wf*N + j] = 1'b1;
                nxt.fix.valid[j] = 1'b1;
                nxt.fix.data[j*W +: W] = inData[wf*W +: W];
                nxt.fix.src[j*PW +: PW] = PW'(wf);
            end
            if (wr >= 0) begin
                expGntRr[wr*N + j] = 1'b1;
                nxt.rr.valid[j] = 1'b1;
                nxt.rr.data[j*W +: W] = inData[wr*W +: W];
                nxt.rr.src[j*PW +: PW] = PW'(wr);
                mPtr[j] = (wr + 1) % N;
            end
        end
        mFix = nxt.fix;
        mRr  = nxt.rr;
        sbq.push_back(nxt);
    endtask

    task automatic applyStimulus(input logic [N-1:0] v, input logic [N*N-1:0] r,
                                 input logic [N-1:0] s);
        inValid  = v;
        inReq    = r;
        outStall = s;
    endtask

    task automatic applyReset();
        @(negedge clk);
        reset = 1'b1;
        #1;
        clearModel();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        testsRun++;
        if ({outValidFix, outDataFix, outSrcFix} !== '0 || {outValidRr, outDataRr, outSrcRr} !== '0) begin
            testsFailed++;
            $display("[TB] FAIL reset_outputs: got fix %h/%h rr %h/%h, want all zero",
                     outValidFix, outSrcFix, outValidRr, outSrcRr);
        end
        clearModel();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_basic_route();
        expPair_t exp;
        logic [N*N-1:0] r;
        @(negedge clk);
        r = '0;
        for (int i = 0; i < N; i++) begin
            r[i*N + (i+1)%N] = 1'b1;
            inData[i*W +: W] = 64'hA0 + 64'(i);
        end
        applyStimulus(4'hF, r, 4'h0);
        #1;
        stepModel();
        testsRun++;
        if (gntFix !== expGntFix || gntFix !== 16'h1842) begin
            testsFailed++;
            $display("[TB] FAIL basic_gnt_fix: got %h want %h", gntFix, 16'h1842);
        end
        testsRun++;
        if (gntRr !== expGntRr) begin
            testsFailed++;
            $display("[TB] FAIL basic_gnt_rr: got %h want %h", gntRr, expGntRr);
        end
        @(posedge clk);
        #1;
        exp = sbq.pop_front();
        testsRun++;
        if ({outValidFix, outDataFix, outSrcFix} !== exp.fix ||
            outDataFix !== {64'hA2, 64'hA1, 64'hA0, 64'hA3} || outValidFix !== 4'hF) begin
            testsFailed++;
            $display("[TB] FAIL basic_out_fix: got %h %h want %h", outValidFix, outDataFix, exp.fix);
        end
        testsRun++;
        if ({outValidRr, outDataRr, outSrcRr} !== exp.rr) begin
            testsFailed++;
            $display("[TB] FAIL basic_out_rr: got %h %h want %h", outValidRr, outDataRr, exp.rr);
        end
    endtask

    task automatic test_fixed_conflict();
        expPair_t exp;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            applyStimulus(4'hE, 16'h1110, 4'h0);
            #1;
            stepModel();
            testsRun++;
            if (gntFix !== 16'h0010 || gntFix !== expGntFix) begin
                testsFailed++;
                $display("[TB] FAIL conflict_gnt_fix: got %h want %h", gntFix, 16'h0010);
            end
            testsRun++;
            if (gntRr !== expGntRr) begin
                testsFailed++;
                $display("[TB] FAIL conflict_gnt_rr: got %h want %h", gntRr, expGntRr);
            end
            @(posedge clk);
            #1;
            exp = sbq.pop_front();
            testsRun++;
            if ({outValidFix, outDataFix, outSrcFix} !== exp.fix || outSrcFix[1:0] !== 2'd1) begin
                testsFailed++;
                $display("[TB] FAIL conflict_out_fix: got src %h want %h", outSrcFix, exp.fix.src);
            end
            testsRun++;
            if ({outValidRr, outDataRr, outSrcRr} !== exp.rr) begin
                testsFailed++;
                $display("[TB] FAIL conflict_out_rr: got src %h want %h", outSrcRr, exp.rr.src);
            end
        end
    endtask

    task automatic test_rr_fairness();
        expPair_t exp;
        logic [N*N-1:0] lit;
        applyReset();
        for (int c = 0; c < 8; c++) begin
            if (c != 0) @(negedge clk);
            applyStimulus(4'hF, 16'h4444, 4'h0);
            #1;
            stepModel();
            lit = '0;
            lit[(c % N)*N + 2] = 1'b1;
            testsRun++;
            if (gntRr !== lit || gntRr !== expGntRr) begin
                testsFailed++;
                $display("[TB] FAIL rr_gnt cycle %0d: got %h want %h", c, gntRr, lit);
            end
            testsRun++;
            if (gntFix !== 16'h0004) begin
                testsFailed++;
                $display("[TB] FAIL rr_gnt_fix cycle %0d: got %h want %h", c, gntFix, 16'h0004);
            end
            @(posedge clk);
            #1;
            exp = sbq.pop_front();
            testsRun++;
            if ({outValidRr, outDataRr, outSrcRr} !== exp.rr ||
                {outValidFix, outDataFix, outSrcFix} !== exp.fix) begin
                testsFailed++;
                $display("[TB] FAIL rr_out cycle %0d: got rr src %h fix src %h want %h %h",
                         c, outSrcRr, outSrcFix, exp.rr.src, exp.fix.src);
            end
        end
    endtask

    task automatic test_multicast();
        expPair_t exp;
        @(negedge clk);
        inData[2*W +: W] = 64'hBEEF;
        applyStimulus(4'hF, 16'h0900, 4'h0);
        #1;
        stepModel();
        testsRun++;
        if (gntFix !== 16'h0900 || gntRr !== 16'h0900) begin
            testsFailed++;
            $display("[TB] FAIL mcast_gnt: got %h %h want %h", gntFix, gntRr, 16'h0900);
        end
        @(posedge clk);
        #1;
        exp = sbq.pop_front();
        testsRun++;
        if (outValidFix !== 4'b1001 || outDataFix[0 +: W] !== 64'hBEEF ||
            outDataFix[3*W +: W] !== 64'hBEEF || outSrcFix !== 8'h82 ||
            {outValidFix, outDataFix, outSrcFix} !== exp.fix) begin
            testsFailed++;
            $display("[TB] FAIL mcast_out_fix: got %h %h %h want %h", outValidFix, outDataFix, outSrcFix, exp.fix);
        end
        testsRun++;
        if (outValidRr !== 4'b1001 || outSrcRr !== 8'h82 ||
            {outValidRr, outDataRr, outSrcRr} !== exp.rr) begin
            testsFailed++;
            $display("[TB] FAIL mcast_out_rr: got %h %h %h want %h", outValidRr, outDataRr, outSrcRr, exp.rr);
        end
    endtask

    task automatic test_stall();
        expPair_t exp;
        @(negedge clk);
        inData[0 +: W] = 64'h55;
        applyStimulus(4'h1, 16'h0002, 4'h0);
        #1;
        stepModel();
        @(posedge clk);
        #1;
        exp = sbq.pop_front();
        testsRun++;
        if (outDataFix[W +: W] !== 64'h55 || {outValidRr, outDataRr, outSrcRr} !== exp.rr) begin
            testsFailed++;
            $display("[TB] FAIL stall_setup: got %h want %h", outDataFix[W +: W], 64'h55);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            inData[0 +: W] = 64'h66;
            applyStimulus(4'h1, 16'h0002, 4'h2);
            #1;
            stepModel();
            testsRun++;
            if (gntFix[1] !== 1'b0 || gntRr[1] !== 1'b0) begin
                testsFailed++;
                $display("[TB] FAIL stall_gnt cycle %0d: got %h %h want 0", c, gntFix, gntRr);
            end
            @(posedge clk);
            #1;
            exp = sbq.pop_front();
            testsRun++;
            if (outDataFix[W +: W] !== 64'h55 || outValidFix[1] !== 1'b1 ||
                {outValidFix, outDataFix, outSrcFix} !== exp.fix ||
                {outValidRr, outDataRr, outSrcRr} !== exp.rr) begin
                testsFailed++;
                $display("[TB] FAIL stall_hold cycle %0d: got %h %h want 55", c, outDataFix[W +: W], outDataRr[W +: W]);
            end
        end
        @(negedge clk);
        applyStimulus(4'h1, 16'h0002, 4'h0);
        #1;
        stepModel();
        @(posedge clk);
        #1;
        exp = sbq.pop_front();
        testsRun++;
        if (outDataFix[W +: W] !== 64'h66 || outDataRr[W +: W] !== 64'h66 ||
            {outValidRr, outDataRr, outSrcRr} !== exp.rr) begin
            testsFailed++;
            $display("[TB] FAIL stall_release: got %h %h want 66", outDataFix[W +: W], outDataRr[W +: W]);
        end
    endtask

    task automatic test_back_to_back();
        expPair_t exp;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            inData = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            applyStimulus(N'($urandom), 16'($urandom),
                          N'($urandom & $urandom));
            #1;
            stepModel();
            testsRun++;
            if (gntFix !== expGntFix || gntRr !== expGntRr) begin
                testsFailed++;
                $display("[TB] FAIL b2b_gnt cycle %0d: got %h %h want %h %h", c, gntFix, gntRr, expGntFix, expGntRr);
            end
            @(posedge clk);
            #1;
            exp = sbq.pop_front();
            testsRun++;
            if ({outValidFix, outDataFix, outSrcFix} !== exp.fix ||
                {outValidRr, outDataRr, outSrcRr} !== exp.rr) begin
                testsFailed++;
                $display("[TB] FAIL b2b_out cycle %0d: got %h/%h want %h/%h", c,
                         outValidFix, outValidRr, exp.fix.valid, exp.rr.valid);
            end
        end
    endtask

    task automatic test_async_reset();
        expPair_t exp;
        logic [N*N-1:0] r;
        @(negedge clk);
        r = '0;
        for (int i = 0; i < N; i++) begin
            r[i*N + (i+1)%N] = 1'b1;
            inData[i*W +: W] = 64'hA0 + 64'(i);
        end
        applyStimulus(4'hF, r, 4'h0);
        #1;
        stepModel();
        @(posedge clk);
        #1;
        exp = sbq.pop_front();
        testsRun++;
        if (outValidFix !== 4'hF || outValidRr !== 4'hF || {outValidRr, outDataRr, outSrcRr} !== exp.rr) begin
            testsFailed++;
            $display("[TB] FAIL areset_fill: got %h %h want f", outValidFix, outValidRr);
        end
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        clearModel();
        testsRun++;
        if ({outValidFix, outDataFix, outSrcFix} !== '0 || {outValidRr, outDataRr, outSrcRr} !== '0) begin
            testsFailed++;
            $display("[TB] FAIL areset_clear: got %h %h want 0", outValidFix, outValidRr);
        end
        testsRun++;
        if (gntFix !== 16'h1842 || gntRr !== 16'h1842) begin
            testsFailed++;
            $display("[TB] FAIL areset_gnt: got %h %h want %h", gntFix, gntRr, 16'h1842);
        end
        @(negedge clk);
        reset = 1'b0;
        applyStimulus(4'hF, 16'hFFFF, 4'h0);
        #1;
        stepModel();
        testsRun++;
        if (gntRr !== 16'h000F || gntFix !== 16'h000F || gntRr !== expGntRr) begin
            testsFailed++;
            $display("[TB] FAIL areset_first_rr: got %h %h want %h", gntRr, gntFix, 16'h000F);
        end
        @(posedge clk);
        #1;
        exp = sbq.pop_front();
        testsRun++;
        if ({outValidRr, outDataRr, outSrcRr} !== exp.rr || outSrcRr !== 8'h00 || outValidRr !== 4'hF) begin
            testsFailed++;
            $display("[TB] FAIL areset_first_out: got %h %h want %h", outValidRr, outSrcRr, exp.rr.src);
        end
    endtask

    initial begin
        test_reset();
        test_basic_route();
        test_fixed_conflict();
        test_rr_fairness();
        test_multicast();
        test_stall();
        test_back_to_back();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
